// File: rtl/voice_allocator.sv
// voice_allocator: polyphony scheduler between a note-event source and a bank
// of midi_player voices. Note-on events are given to a voice. The preference
// order is: a voice already holding the note, then an idle voice, then the
// releasing voice closest to finishing, and finally the least recently used
// held voice, which is stolen.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ev_valid      event present
//   ev_ready      allocator accepts an event this cycle (low in reset / STEAL)
//   ev_note_on    1 = note-on, 0 = note-off
//   ev_note       MIDI note number (bit 7 set = ignored event)
//   voice_note    per-voice midi_data, voice i at [8i+7:8i]
//   voice_gate    per-voice midi_valid (key held)
//   voice_active  voice not idle
//   steal_count   saturating count of held voices stolen
module voice_allocator #(
    parameter int unsigned NUM_VOICES     = 4,
    parameter int unsigned RELEASE_CYCLES = 30000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_note_on,
    input  logic [7:0]              ev_note,
    output logic [8*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [15:0]             steal_count
);

    localparam int unsigned IdxW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {StIdle, StHeld, StRelease, StSteal} vstate_e;

    vstate_e         state_q [NUM_VOICES];
    vstate_e         state_d [NUM_VOICES];
    logic [7:0]      note_q  [NUM_VOICES];
    logic [7:0]      note_d  [NUM_VOICES];
    logic            gate_q  [NUM_VOICES];
    logic            gate_d  [NUM_VOICES];
    logic [15:0]     cnt_q   [NUM_VOICES];
    logic [15:0]     cnt_d   [NUM_VOICES];
    logic [IdxW-1:0] rank_q  [NUM_VOICES];
    logic [IdxW-1:0] rank_d  [NUM_VOICES];
    logic [15:0]     steal_q, steal_d;

    // Voice selection, all based on state before the edge.
    logic            stealing, held_hit;
    logic            idle_found, rel_found, old_found, off_found;
    logic [IdxW-1:0] idle_idx, rel_idx, old_idx, off_idx, old_rank;
    logic [15:0]     rel_min;

    always_comb begin
        stealing   = 1'b0;
        held_hit   = 1'b0;
        idle_found = 1'b0;
        rel_found  = 1'b0;
        old_found  = 1'b0;
        off_found  = 1'b0;
        idle_idx   = '0;
        rel_idx    = '0;
        old_idx    = '0;
        off_idx    = '0;
        old_rank   = '0;
        rel_min    = '1;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (state_q[i] == StSteal) stealing = 1'b1;
            if (state_q[i] == StHeld && note_q[i] == ev_note) begin
                held_hit = 1'b1;
                if (!off_found) begin
                    off_found = 1'b1;
                    off_idx   = IdxW'(i);
                end
            end
            if (!idle_found && state_q[i] == StIdle) begin
                idle_found = 1'b1;
                idle_idx   = IdxW'(i);
            end
            // Strict compare keeps the lowest index on a counter tie.
            if (state_q[i] == StRelease && (!rel_found || cnt_q[i] < rel_min)) begin
                rel_found = 1'b1;
                rel_idx   = IdxW'(i);
                rel_min   = cnt_q[i];
            end
            if (state_q[i] == StHeld && (!old_found || rank_q[i] > old_rank)) begin
                old_found = 1'b1;
                old_idx   = IdxW'(i);
                old_rank  = rank_q[i];
            end
        end
    end

    assign ev_ready = !rst && !stealing;

    logic            accept, do_alloc, do_off, alloc_steal;
    logic [IdxW-1:0] alloc_idx;

    always_comb begin
        accept      = ev_valid && ev_ready && !ev_note[7];
        do_alloc    = 1'b0;
        alloc_steal = 1'b0;
        alloc_idx   = '0;
        if (accept && ev_note_on && !held_hit) begin
            do_alloc = 1'b1;
            if (idle_found) begin
                alloc_idx = idle_idx;
            end else if (rel_found) begin
                alloc_idx = rel_idx;
            end else begin
                alloc_idx   = old_idx;
                alloc_steal = 1'b1;
            end
        end
        do_off = accept && !ev_note_on && off_found;

        steal_d = steal_q;
        if (alloc_steal && steal_q != 16'hFFFF) steal_d = steal_q + 16'd1;

        for (int i = 0; i < NUM_VOICES; i++) begin
            state_d[i] = state_q[i];
            note_d[i]  = note_q[i];
            gate_d[i]  = gate_q[i];
            cnt_d[i]   = cnt_q[i];
            rank_d[i]  = rank_q[i];

            case (state_q[i])
                StSteal: begin
                    state_d[i] = StHeld;
                    gate_d[i]  = 1'b1;
                end
                StRelease: begin
                    if (cnt_q[i] == 16'd0) state_d[i] = StIdle;
                    else                   cnt_d[i]   = cnt_q[i] - 16'd1;
                end
                default: ;
            endcase

            // Allocation overrides a release expiring on the same edge.
            if (do_alloc) begin
                if (alloc_idx == IdxW'(i)) begin
                    note_d[i] = ev_note;
                    rank_d[i] = '0;
                    if (alloc_steal) begin
                        state_d[i] = StSteal;
                        gate_d[i]  = 1'b0;
                    end else begin
                        state_d[i] = StHeld;
                        gate_d[i]  = 1'b1;
                    end
                end else if (rank_q[i] < rank_q[alloc_idx]) begin
                    rank_d[i] = rank_q[i] + 1'b1;
                end
            end

            if (do_off && off_idx == IdxW'(i)) begin
                state_d[i] = StRelease;
                gate_d[i]  = 1'b0;
                cnt_d[i]   = 16'(RELEASE_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= StIdle;
                note_q[i]  <= '0;
                gate_q[i]  <= 1'b0;
                cnt_q[i]   <= '0;
                rank_q[i]  <= IdxW'(i);
            end
            steal_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= state_d[i];
                note_q[i]  <= note_d[i];
                gate_q[i]  <= gate_d[i];
                cnt_q[i]   <= cnt_d[i];
                rank_q[i]  <= rank_d[i];
            end
            steal_q <= steal_d;
        end
    end

    always_comb begin
        voice_note   = '0;
        voice_gate   = '0;
        voice_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[8*i +: 8] = note_q[i];
            voice_gate[i]        = gate_q[i];
            voice_active[i]      = (state_q[i] != StIdle);
        end
    end

    assign steal_count = steal_q;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler placed between the note-event source (keyboard/MIDI parser) and a bank of NUM_VOICES midi_player instances.
- Accepts note-on/note-off events and assigns each note to a voice.
- Drives each voice's midi_data/midi_valid pair.
- Holds a released voice reserved until its ADSR release has finished, and steals voices least-recently-used when all are busy.

Parameters:
- NUM_VOICES, 4: number of midi_player voices driven; power of two, 2..8.
- RELEASE_CYCLES, 30000: cycles a voice stays reserved after note-off (ADSR release time); 16-bit max.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ev_valid  input  1  event present.
- ev_ready  output  1  allocator can accept an event this cycle.
- ev_note_on  input  1  1 = note-on, 0 = note-off.
- ev_note  input  8  MIDI note number.
- voice_note  output  8*NUM_VOICES  per-voice midi_data; voice i at bits [8i+7:8i].
- voice_gate  output  NUM_VOICES  per-voice midi_valid (high = key held).
- voice_active  output  NUM_VOICES  voice not IDLE (HELD, RELEASE or STEAL).
- steal_count  output  16  saturating count of HELD voices stolen.

Behaviour:
- Per-voice state: IDLE, HELD, RELEASE, STEAL. Also per voice:
  - 16-bit release counter.
  - LRU rank, clog2(NUM_VOICES) bits; 0 = newest.
- Reset (evaluated at posedge when rst=1):
  - all voices IDLE; voice_note=0, voice_gate=0, voice_active=0.
  - ranks: voice i = i.
  - steal_count=0; ev_ready=0 during reset, 1 on the first cycle after.
- Handshake:
  - event is accepted when ev_valid && ev_ready at posedge.
  - ev_ready = !rst && no voice in STEAL.
  - outputs reflect an accepted event in the following cycle (1-cycle latency).
  - ev_note[7]=1: event accepted, no effect.
- Note-on, first matching rule wins (voice selection uses state before the edge):
  1. A HELD voice already holding ev_note: no change, rank unchanged.
  2. Lowest-index IDLE voice: note<=ev_note, gate<=1, state HELD.
  3. RELEASE voice with the smallest release counter (tie: lowest index): release cancelled, note<=ev_note, gate<=1, state HELD.
  4. Oldest HELD voice (highest rank):
     - note<=ev_note, gate<=0, state STEAL for exactly one cycle, then gate<=1 and state HELD.
     - steal_count increments, saturating at 0xFFFF.
     - ev_ready is low during the STEAL cycle.
- For rules 2-4, the chosen voice gets rank 0. Every voice whose rank was below the chosen voice's old rank increments its rank, so ranks remain a permutation.
- Note-off:
  - lowest-index HELD voice with matching note: gate<=0, counter<=RELEASE_CYCLES-1, state RELEASE.
  - no match: ignored.
  - voice_note is held unchanged through RELEASE.
- RELEASE: counter decrements every cycle; when counter=0 at a posedge, state<=IDLE. voice_note retains its last value.
- Simultaneous event and release expiry on the same voice: the event sees RELEASE (rule 3 applies) and reallocation takes priority over the expiry.
- Note-off for a voice in STEAL: matches only once that voice is HELD. The event cannot be accepted during STEAL anyway, because ev_ready=0.
- rst asserted mid-operation (including STEAL or RELEASE): reset values on the next edge; no partial gate pulse afterwards.
- Gate rules:
  - gate only rises on a voice whose gate has been low for at least 1 cycle.
  - gate never toggles without an accepted event, except the STEAL→HELD rise.

Test Plan:
- Reset, then note-on 72: next cycle voice_gate=0001, voice_note[7:0]=72, voice_active=0001, ev_ready=1.
- Note-on 72, 74, 76, 77 then note-off 74:
  - voices 0-3 hold 72/74/76/77, gates 1111.
  - after note-off, gate=1101 and voice 1 active.
  - voice 1 goes IDLE exactly RELEASE_CYCLES cycles after the note-off was accepted; voice_note[15:8] stays 74.
- Four held notes (72, 74, 76, 77), then note-on 79:
  - voice 0 (oldest) shows gate=0, note=79 for one cycle, with ev_ready=0.
  - then gate=1; steal_count=1.
- Note-off 74 and 76 two cycles apart (RELEASE_CYCLES=100), then note-on 60 while voices 0 and 3 remain HELD and no voice is IDLE: voice 1 (smaller counter) is reused with note 60 and gate=1, no steal.
- Edge cases:
  - note-on 72 twice: one voice used, no steal.
  - note-off 50 (not held): outputs unchanged.
  - ev_note=0x80: accepted, no change.
- rst=1 during the STEAL cycle: next cycle all outputs 0, steal_count=0, ranks 0..3.
